ins_fetch_feeder: RTL

Front-end producer for the issue stage: fetches raw instruction words from instruction memory and presents up to two per cycle to the issue stage's queue through a valid/take handshake. It holds an 8-entry circular buffer, throttles memory requests against free space, and handles branch redirects (flush) and HALT. It drives the instruction inputs that the issue stage's decode and queue consume.

---
 rtl/ins_fetch_feeder_pkg.sv | 28 ++
 rtl/ins_fetch_feeder_if.sv | 43 ++++
 rtl/ins_fetch_feeder_buf.sv | 90 +++++++++
 rtl/ins_fetch_feeder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ins_fetch_feeder_pkg.sv
// Shared types and sizing for the instruction fetch feeder.
// The fetch FSM states, the buffered entry layout and the HALT opcode test live here.
package ins_fetch_pkg;

    localparam int PC_W  = 8;
    localparam int INS_W = 16;
    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [3:0] HALT_OP = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_e;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [PC_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [INS_W-1:0] word);
        return word[INS_W-1 -: 4] == HALT_OP;
    endfunction

endpackage

// File: rtl/ins_fetch_feeder_if.sv
// Memory request/response bus and issue-stage valid/take handshake of the fetch feeder.
// The master modport is the feeder itself; slave is the memory plus issue-stage side.
interface ins_fetch_feeder_if;
    import ins_fetch_pkg::*;

    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata_0;
    logic [INS_W-1:0] imem_rdata_1;
    logic [1:0]       out_vld;
    logic [INS_W-1:0] out_ins_0;
    logic [INS_W-1:0] out_ins_1;
    logic [PC_W-1:0]  out_pc_0;
    logic [PC_W-1:0]  out_pc_1;
    logic [1:0]       take;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata_0,
        input  imem_rdata_1,
        output out_vld,
        output out_ins_0,
        output out_ins_1,
        output out_pc_0,
        output out_pc_1,
        input  take
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata_0,
        output imem_rdata_1,
        input  out_vld,
        input  out_ins_0,
        input  out_ins_1,
        input  out_pc_0,
        input  out_pc_1,
        output take
    );

endinterface

// File: rtl/ins_fetch_feeder_buf.sv
// Circular instruction buffer: up to two pushes and two pops per cycle,
// with combinational reads of the two oldest entries.
module fetch_buf
    import ins_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       enq_n,
    input  fetch_entry_t     enq_0,
    input  fetch_entry_t     enq_1,
    input  logic [1:0]       deq_n,
    output fetch_entry_t     rd_0,
    output fetch_entry_t     rd_1,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;

    fetch_entry_t [DEPTH-1:0] slots;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_n);
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is reset so the out_* reads are zero straight out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_q, slot_d;
            logic         wr0, wr1;

            assign wr0 = !clr && (enq_n != 2'd0) && (tail_q == PTR_W'(gi));
            assign wr1 = !clr && (enq_n == 2'd2) && (tail_p1 == PTR_W'(gi));

            always_comb begin
                slot_d = slot_q;
                if (wr0) begin
                    slot_d = enq_0;
                end else if (wr1) begin
                    slot_d = enq_1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign slots[gi] = slot_q;
        end
    endgenerate

    assign rd_0  = slots[head_q];
    assign rd_1  = slots[head_p1];
    assign count = count_q;

endmodule

// File: rtl/ins_fetch_feeder.sv
// Fetch front end: requests instruction pairs from memory, buffers them and
// presents up to two per cycle to the issue stage; handles redirects and HALT.
module ins_fetch_feeder
    import ins_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PC_W-1:0]     start_pc,
    input  logic                flush,
    input  logic [PC_W-1:0]     redirect_pc,
    ins_fetch_feeder_if.master  bus,
    output logic                halted
);

    localparam logic [CNT_W:0] REQ_LIMIT = (CNT_W + 1)'(DEPTH - 2);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             pending_q, pending_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   need;
    logic             req;
    logic             resp_ok;
    logic             halt0, halt1;
    logic [1:0]       enq_n;
    logic [1:0]       deq_n;
    fetch_entry_t     enq_0, enq_1;
    fetch_entry_t     rd_0, rd_1;

    assign halt0 = is_halt(bus.imem_rdata_0);
    assign halt1 = is_halt(bus.imem_rdata_1);

    assign enq_0 = '{ins: bus.imem_rdata_0, pc: req_pc_q};
    assign enq_1 = '{ins: bus.imem_rdata_1, pc: req_pc_q + PC_W'(1)};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = 1'b0;
        req_pc_d  = req_pc_q;

        // Room is judged before this cycle's take, counting the in-flight pair.
        need    = {1'b0, count} + (pending_q ? (CNT_W + 1)'(2) : '0);
        req     = (state_q == RUN) && !flush && (need <= REQ_LIMIT);
        resp_ok = pending_q && (state_q == RUN) && !flush;

        enq_n = 2'd0;
        if (resp_ok) begin
            enq_n = halt0 ? 2'd1 : 2'd2;
        end

        deq_n = 2'd0;
        if (!flush && bus.take[0]) begin
            deq_n = bus.take[1] ? 2'd2 : 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_pc;
                end
            end
            RUN: begin
                if (resp_ok && (halt0 || halt1)) begin
                    state_d = HALTED;
                end
            end
            default: begin
            end
        endcase

        if (req) begin
            pc_d      = pc_q + PC_W'(2);
            pending_d = 1'b1;
            req_pc_d  = pc_q;
        end

        if (flush) begin
            state_d   = RUN;
            pc_d      = redirect_pc;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            pending_q <= 1'b0;
            req_pc_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            req_pc_q  <= req_pc_d;
        end
    end

    fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .enq_n (enq_n),
        .enq_0 (enq_0),
        .enq_1 (enq_1),
        .deq_n (deq_n),
        .rd_0  (rd_0),
        .rd_1  (rd_1),
        .count (count)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.out_ins_0 = rd_0.ins;
    assign bus.out_pc_0  = rd_0.pc;
    assign bus.out_ins_1 = rd_1.ins;
    assign bus.out_pc_1  = rd_1.pc;
    assign bus.out_vld   = (count == '0)          ? 2'b00 :
                           (count == CNT_W'(1))   ? 2'b01 : 2'b11;
    assign halted        = (state_q == HALTED);

    a_take_legal: assert property (@(posedge clk) disable iff (rst)
        ((bus.take & ~bus.out_vld) == 2'b00) && (bus.take != 2'b10));

endmodule
